// File: rtl/mem_multiport_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_multiport_pkg
// Description : Shared definitions for the multi-port memory. Holds the
//               sequencer state encoding, the collision counter width and the
//               byte-lane width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_multiport_pkg;

  localparam int COUNT_WIDTH = 16;
  localparam int BYTE_WIDTH  = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_multiport_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_multiport_if
// Description : Bus bundle for mem_multiport. Carries the packed read ports,
//               the packed write ports with byte masks, and the status
//               outputs.
// Ports       : master - drives addresses/write data, receives read data and
//                        status (the client side)
//               slave  - the memory side
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_multiport_if
  import mem_multiport_pkg::*;
#(
  parameter int ADDRESSWIDTH = 10,
  parameter int DEPTH        = 1024,
  parameter int WIDTH        = 32,
  parameter int NREAD        = 2,
  parameter int NWRITE       = 2
) ();

  logic [NREAD*ADDRESSWIDTH-1:0]         readAddress;
  logic [NREAD*WIDTH-1:0]                readData;
  logic [NWRITE-1:0]                     writeEnable;
  logic [NWRITE*ADDRESSWIDTH-1:0]        writeAddress;
  logic [NWRITE*WIDTH-1:0]               writeData;
  logic [NWRITE*(WIDTH/BYTE_WIDTH)-1:0]  writeByteEnable;
  logic                                  ready;
  logic [COUNT_WIDTH-1:0]                collisionCount;

  modport master (
    output readAddress, writeEnable, writeAddress, writeData, writeByteEnable,
    input  readData, ready, collisionCount
  );

  modport slave (
    input  readAddress, writeEnable, writeAddress, writeData, writeByteEnable,
    output readData, ready, collisionCount
  );

endinterface
`default_nettype wire

// File: rtl/mem_write_merge.sv
`default_nettype none
// ============================================================================
// Module      : mem_write_merge
// Description : Combinational write-port merger. For one target address it
//               builds the merged word and lane mask from every enabled,
//               in-range port that addresses it; on a shared lane the
//               highest-indexed port wins. Also flags any pair of enabled
//               ports carrying equal in-range addresses.
// Ports       : write_enable/write_address/write_data/write_byte_enable -
//                 packed write ports
//               target      - address being resolved
//               merged_data - merged word for target
//               lane_mask   - lanes of target written this cycle
//               collision   - two enabled ports share an in-range address
// Revision    : 1.0 - initial release
// ============================================================================
module mem_write_merge
  import mem_multiport_pkg::*;
#(
  parameter int ADDRESSWIDTH = 10,
  parameter int DEPTH        = 1024,
  parameter int WIDTH        = 32,
  parameter int NWRITE       = 2
) (
  input  logic [NWRITE-1:0]                    write_enable,
  input  logic [NWRITE*ADDRESSWIDTH-1:0]       write_address,
  input  logic [NWRITE*WIDTH-1:0]              write_data,
  input  logic [NWRITE*(WIDTH/BYTE_WIDTH)-1:0] write_byte_enable,
  input  logic [ADDRESSWIDTH-1:0]              target,
  output logic [WIDTH-1:0]                     merged_data,
  output logic [WIDTH/BYTE_WIDTH-1:0]          lane_mask,
  output logic                                 collision
);

  localparam int LANES = WIDTH / BYTE_WIDTH;
  // One extra bit so DEPTH == 2^ADDRESSWIDTH is representable.
  localparam logic [ADDRESSWIDTH:0] DEPTH_W = (ADDRESSWIDTH+1)'(DEPTH);

  logic [ADDRESSWIDTH-1:0] addr [NWRITE];
  logic                    live [NWRITE];

  for (genvar j = 0; j < NWRITE; j++) begin : g_decode
    assign addr[j] = write_address[j*ADDRESSWIDTH +: ADDRESSWIDTH];
    assign live[j] = write_enable[j] && ({1'b0, addr[j]} < DEPTH_W);
  end

  // Ascending scan: a later (higher) port overwrites an earlier one per lane.
  always_comb begin
    merged_data = '0;
    lane_mask   = '0;
    for (int j = 0; j < NWRITE; j++) begin
      for (int b = 0; b < LANES; b++) begin
        if (live[j] && (addr[j] == target) && write_byte_enable[j*LANES + b]) begin
          merged_data[b*BYTE_WIDTH +: BYTE_WIDTH] =
            write_data[j*WIDTH + b*BYTE_WIDTH +: BYTE_WIDTH];
          lane_mask[b] = 1'b1;
        end
      end
    end
  end

  // Byte masks are deliberately ignored: address equality alone is a conflict.
  always_comb begin
    collision = 1'b0;
    for (int j = 0; j < NWRITE; j++) begin
      for (int k = j + 1; k < NWRITE; k++) begin
        if (live[j] && live[k] && (addr[j] == addr[k])) begin
          collision = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_multiport.sv
`default_nettype none
// ============================================================================
// Module      : mem_multiport
// Description : Parametrised memory with NREAD asynchronous read ports and
//               NWRITE synchronous byte-masked write ports. After reset a
//               sequencer zeroes every word before raising ready. Same-address
//               write cycles are counted in a saturating counter.
// Ports       : clk     - clock, all state on posedge
//               reset_n - synchronous active-low reset
//               bus     - mem_multiport_if.slave (read/write ports, ready,
//                         collisionCount)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_multiport
  import mem_multiport_pkg::*;
#(
  parameter int ADDRESSWIDTH = 10,
  parameter int DEPTH        = 1024,
  parameter int WIDTH        = 32,
  parameter int NREAD        = 2,
  parameter int NWRITE       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_multiport_if.slave   bus
);

  localparam int LANES = WIDTH / BYTE_WIDTH;
  // Array index width; addresses are range-checked before being narrowed.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRESSWIDTH:0]   DEPTH_W    = (ADDRESSWIDTH+1)'(DEPTH);
  localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR  = ADDRESSWIDTH'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  state_t                  state;
  state_t                  state_next;
  logic [ADDRESSWIDTH-1:0] clear_ptr;
  logic [COUNT_WIDTH-1:0]  collision_count;

  logic [ADDRESSWIDTH-1:0] waddr      [NWRITE];
  logic                    port_valid [NWRITE];
  logic [WIDTH-1:0]        merged     [NWRITE];
  logic [LANES-1:0]        lane_mask  [NWRITE];
  logic [NWRITE-1:0]       collision_vec;
  logic                    collision;

  // One merger per write port, resolved against that port's own address.
  // Ports sharing an address therefore compute identical merged words, so
  // the order in which they are applied below does not matter.
  for (genvar j = 0; j < NWRITE; j++) begin : g_write
    assign waddr[j]      = bus.writeAddress[j*ADDRESSWIDTH +: ADDRESSWIDTH];
    assign port_valid[j] = bus.writeEnable[j] && ({1'b0, waddr[j]} < DEPTH_W);

    mem_write_merge #(
      .ADDRESSWIDTH (ADDRESSWIDTH),
      .DEPTH        (DEPTH),
      .WIDTH        (WIDTH),
      .NWRITE       (NWRITE)
    ) u_merge (
      .write_enable      (bus.writeEnable),
      .write_address     (bus.writeAddress),
      .write_data        (bus.writeData),
      .write_byte_enable (bus.writeByteEnable),
      .target            (waddr[j]),
      .merged_data       (merged[j]),
      .lane_mask         (lane_mask[j]),
      .collision         (collision_vec[j])
    );
  end

  // Every instance reports the same flag; OR-ing keeps all outputs in use.
  assign collision = |collision_vec;

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clear_ptr == LAST_ADDR) state_next = READY;
      READY:   state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clear_ptr <= '0;
    end else if (state == CLEAR) begin
      clear_ptr <= (clear_ptr == LAST_ADDR) ? '0 : clear_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      collision_count <= '0;
    end else if ((state == READY) && collision && (collision_count != '1)) begin
      collision_count <= collision_count + 1'b1;
    end
  end

  // Storage: the clear sequencer owns the array until READY.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state == CLEAR) begin
        mem[clear_ptr[IDX_W-1:0]] <= '0;
      end else begin
        for (int j = 0; j < NWRITE; j++) begin
          for (int b = 0; b < LANES; b++) begin
            if (port_valid[j] && lane_mask[j][b]) begin
              mem[waddr[j][IDX_W-1:0]][b*BYTE_WIDTH +: BYTE_WIDTH] <=
                merged[j][b*BYTE_WIDTH +: BYTE_WIDTH];
            end
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [ADDRESSWIDTH-1:0] raddr;
    assign raddr = bus.readAddress[i*ADDRESSWIDTH +: ADDRESSWIDTH];
    assign bus.readData[i*WIDTH +: WIDTH] =
      ((state == READY) && ({1'b0, raddr} < DEPTH_W)) ? mem[raddr[IDX_W-1:0]] : '0;
  end

  assign bus.ready          = (state == READY);
  assign bus.collisionCount = collision_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_multiport.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_multiport
// Description : Directed self-checking bench for mem_multiport with DEPTH=16,
//               ADDRESSWIDTH=5, two read and two write ports. Expected values
//               come from a reference word array and a collision counter
//               model kept in the bench.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_multiport;

  localparam int AW = 5;
  localparam int DP = 16;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_multiport_if #(.ADDRESSWIDTH(AW), .DEPTH(DP), .WIDTH(W), .NREAD(2), .NWRITE(2)) bus ();

  mem_multiport #(.ADDRESSWIDTH(AW), .DEPTH(DP), .WIDTH(W), .NREAD(2), .NWRITE(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mdl [DP];
  logic [15:0] exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl_read(input logic [4:0] a);
    return (a < DP) ? mdl[a[3:0]] : 32'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DP; i++) mdl[i] = 32'h0;
    exp_cnt = 16'h0;
  endtask

  // One write cycle on both ports; checks the counter right after the edge.
  task automatic wr(input logic e0, input logic [4:0] a0, input logic [31:0] d0, input logic [3:0] m0,
                    input logic e1, input logic [4:0] a1, input logic [31:0] d1, input logic [3:0] m1);
    logic        en [2];
    logic [4:0]  ad [2];
    logic [31:0] dt [2];
    logic [3:0]  mk [2];
    en[0] = e0; ad[0] = a0; dt[0] = d0; mk[0] = m0;
    en[1] = e1; ad[1] = a1; dt[1] = d1; mk[1] = m1;
    @(negedge clk);
    bus.writeEnable     = {e1, e0};
    bus.writeAddress    = {a1, a0};
    bus.writeData       = {d1, d0};
    bus.writeByteEnable = {m1, m0};
    for (int j = 0; j < 2; j++) begin
      if (en[j] && ad[j] < DP) begin
        for (int b = 0; b < 4; b++) begin
          if (mk[j][b]) mdl[ad[j][3:0]][b*8 +: 8] = dt[j][b*8 +: 8];
        end
      end
    end
    if (e0 && e1 && a0 == a1 && a0 < DP && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
    exp_q.push_back({16'h0, exp_cnt});
    @(posedge clk);
    #1;
    check("collision_count", {16'h0, bus.collisionCount});
    bus.writeEnable = 2'b00;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    @(negedge clk);
    bus.readAddress = {a1, a0};
    exp_q.push_back(mdl_read(a0));
    exp_q.push_back(mdl_read(a1));
    #1;
    check("read_port0", bus.readData[31:0]);
    check("read_port1", bus.readData[63:32]);
  endtask

  task automatic read_all();
    for (int i = 0; i < DP; i += 2) rd(5'(i), 5'(i + 1));
  endtask

  // Counts the clear sequence edge by edge with writes hammering addr 1/2.
  task automatic clear_wait();
    bus.writeEnable     = 2'b11;
    bus.writeAddress    = {5'd2, 5'd1};
    bus.writeData       = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bus.writeByteEnable = 8'hFF;
    bus.readAddress     = {5'd2, 5'd1};
    for (int k = 1; k <= DP; k++) begin
      @(posedge clk);
      #1;
      exp_q.push_back({31'h0, (k == DP)});
      check("ready_during_clear", {31'h0, bus.ready});
      exp_q.push_back(32'h0);
      check("read_during_clear", bus.readData[31:0]);
    end
    bus.writeEnable = 2'b00;
  endtask

  initial begin
    reset_n             = 1'b0;
    bus.readAddress     = '0;
    bus.writeEnable     = 2'b11;
    bus.writeAddress    = {5'd2, 5'd1};
    bus.writeData       = '1;
    bus.writeByteEnable = '1;
    model_clear();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(32'h0); check("reset_ready", {31'h0, bus.ready});
    exp_q.push_back(32'h0); check("reset_count", {16'h0, bus.collisionCount});
    exp_q.push_back(32'h0); check("reset_read",  bus.readData[31:0]);

    // Clear sequence, then every word must be zero.
    @(negedge clk);
    reset_n = 1'b1;
    clear_wait();
    read_all();

    // Full-word write, read back on port 1.
    wr(1'b1, 5'd3, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 32'h0, 4'h0);
    rd(5'd0, 5'd3);

    // Lane merge from two ports into one word, counted as a collision.
    wr(1'b1, 5'd5, 32'h11111111, 4'h3, 1'b1, 5'd5, 32'h22222222, 4'hC);
    rd(5'd5, 5'd5);

    // Same lanes: higher port wins.
    wr(1'b1, 5'd7, 32'hAAAAAAAA, 4'hF, 1'b1, 5'd7, 32'h55555555, 4'hF);
    rd(5'd7, 5'd3);

    // Out-of-range addresses: dropped and not counted.
    wr(1'b1, 5'd20, 32'h12345678, 4'hF, 1'b0, 5'd0, 32'h0, 4'h0);
    wr(1'b1, 5'd20, 32'h12345678, 4'hF, 1'b1, 5'd20, 32'h87654321, 4'hF);
    rd(5'd20, 5'd4);

    // Zero mask: collision counted, data unchanged.
    wr(1'b1, 5'd9, 32'hCAFEF00D, 4'h0, 1'b1, 5'd9, 32'hBADC0DE5, 4'h0);
    rd(5'd9, 5'd5);

    // Distinct addresses on both ports in one cycle.
    wr(1'b1, 5'd15, 32'h0F0F0F0F, 4'hF, 1'b1, 5'd0, 32'hF0F0F0F0, 4'h5);
    read_all();

    // Saturation: hold a masked collision for 65536 cycles.
    @(negedge clk);
    bus.writeEnable     = 2'b11;
    bus.writeAddress    = {5'd0, 5'd0};
    bus.writeByteEnable = 8'h00;
    for (int i = 0; i < 65536; i++) begin
      @(posedge clk);
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
    end
    #1;
    exp_q.push_back({16'h0, exp_cnt});
    check("count_saturated", {16'h0, bus.collisionCount});
    @(posedge clk);
    #1;
    exp_q.push_back(32'h0000FFFF);
    check("count_holds", {16'h0, bus.collisionCount});
    bus.writeEnable = 2'b00;

    // Reset from READY, then a second reset mid-clear restarts from addr 0.
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    exp_q.push_back(32'h0); check("rst_count", {16'h0, bus.collisionCount});
    exp_q.push_back(32'h0); check("rst_ready", {31'h0, bus.ready});
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(32'h0); check("midclear_count", {16'h0, bus.collisionCount});
    exp_q.push_back(32'h0); check("midclear_ready", {31'h0, bus.ready});
    @(negedge clk);
    reset_n = 1'b1;
    clear_wait();
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_multiport.md
# mem_multiport

Parametrised multi-port memory, successor to the team's fixed three-port `memoryReg`. It provides NREAD asynchronous read ports and NWRITE synchronous write ports with per-byte write enables. Same-address write conflicts resolve deterministically and are counted. A post-reset clear sequencer zeroes every word before the block reports ready. It sits wherever the CPU datapath needs a register file or data memory with more than one writer.

## Interface
- `ADDRESSWIDTH`, default 10: address bits per port.
- `DEPTH`, default 1024: number of words; must be ≤ 2^ADDRESSWIDTH.
- `WIDTH`, default 32: word width; must be a multiple of 8.
- `NREAD`, default 2: read ports, ≥ 1.
- `NWRITE`, default 2: write ports, ≥ 1.
- `clk` in 1: single clock; all state updates on posedge.
- `reset_n` in 1: reset, synchronous, active-low.
- `readAddress` in NREAD*ADDRESSWIDTH: packed read addresses; port i is slice i.
- `readData` out NREAD*WIDTH: packed read data.
- `writeEnable` in NWRITE: per-port write enable.
- `writeAddress` in NWRITE*ADDRESSWIDTH: packed write addresses.
- `writeData` in NWRITE*WIDTH: packed write data.
- `writeByteEnable` in NWRITE*(WIDTH/8): per-port byte-lane mask; bit 0 = bits 7:0.
- `ready` out 1: high once the clear sequence is complete.
- `collisionCount` out 16: saturating count of write-conflict cycles.

## Operation
- States: CLEAR, READY.
- While `reset_n` is low at a posedge: state becomes CLEAR, clear pointer becomes 0, `ready` becomes 0, and `collisionCount` becomes 0.
- In CLEAR with `reset_n` high: write 0 to mem[pointer], then increment the pointer. After writing DEPTH-1, go to READY and set `ready`=1.
- In CLEAR, all write ports are ignored and every `readData` slice is forced to 0.
- In READY, reads are combinational: `readData[i]` = mem[`readAddress[i]`].
  - A read address ≥ DEPTH returns 0.
- In READY, a write by port j updates byte lane b of mem[`writeAddress[j]`] when `writeEnable[j]` and `writeByteEnable[j][b]` are both 1.
  - A write address ≥ DEPTH is dropped.
- Write conflict rule, per byte lane: when several enabled ports target the same address and the same lane, the highest-indexed port wins. Non-overlapping lanes from different ports merge into the same word in the same cycle.
- Collision: in READY, a cycle in which any two enabled write ports carry equal in-range addresses counts as a collision, regardless of their byte masks.
  - Each collision cycle increments `collisionCount` by 1.
  - The count saturates at 16'hFFFF.
- A write with an all-zero byte mask still participates in collision detection but changes no data.
- A reset during CLEAR restarts the sequence from address 0.
- A reset in READY re-enters CLEAR, so memory is zeroed again.

## Timing
- Read latency is 0 cycles (asynchronous).
- A write at posedge N is visible on any read port immediately after posedge N. There is no bypass of same-cycle write data.
- `ready` rises at the DEPTH-th posedge after the first posedge at which `reset_n` is sampled high.
- `collisionCount` updates at the posedge that performs the conflicting writes.
- Reset values: `ready`=0, `collisionCount`=0, and `readData`=0 throughout CLEAR.

## Structure
- Shared package `mem_multiport_pkg`:
  - state encoding (CLEAR=1'b0, READY=1'b1);
  - COUNT_WIDTH=16;
  - BYTE_WIDTH=8.
- Sub-module `mem_write_merge` (combinational):
  - takes the packed write ports and one target address;
  - produces the per-lane merged data and lane mask with highest-index priority, plus the pairwise equal-address collision flag.
- The top level holds the storage array, the clear FSM and pointer, the saturating counter, and the read muxes.

## Test plan
- Reset, then release with DEPTH=16 → `ready`=0 for 16 posedges, `ready`=1 after the 16th; all 16 words read 0; writes issued during CLEAR have no effect.
- READY, port0 writes 32'hDEADBEEF to addr 3 with mask 4'hF → read port 1 at addr 3 returns 32'hDEADBEEF right after the edge.
- Port0 writes 32'h11111111 with mask 4'h3 and port1 writes 32'h22222222 with mask 4'hC, both to addr 5, in the same cycle → addr 5 reads 32'h22221111 and `collisionCount`=1.
- Both ports write addr 7 with mask 4'hF, port0 data 32'hAAAAAAAA and port1 data 32'h55555555 → addr 7 reads 32'h55555555.
- DEPTH=16, ADDRESSWIDTH=5, write to addr 20 → no word changes; reading addr 20 returns 0; no collision is counted.
- Preload `collisionCount` near saturation by forcing 65 536 collision cycles → the count holds at 16'hFFFF. Assert `reset_n`=0 for one cycle mid-CLEAR → the count returns to 0, `ready` stays 0, and the clear restarts at addr 0.
